// File: rtl/serial_tx.sv
// Serial transmitter: takes a W-bit word on a ready/valid handshake and sends
// a start bit, the word LSB first, and a stop bit, each bit lasting DIV clocks.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | line held at 1, ready asserted, waiting for xv
//   START | start bit (so = 0) for DIV cycles
//   DATA  | captured word shifted out LSB first, DIV cycles per bit
//   STOP  | stop bit (so = 1) for DIV cycles, then back to IDLE
module serial_tx #(
   parameter int W   = 8,
   parameter int DIV = 4
) (
   input  logic         ck,
   input  logic         reset,
   input  logic [W-1:0] x,
   input  logic         xv,
   output logic         ready,
   output logic         so,
   output logic         busy
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state, nstate;
   logic [CW-1:0] cnt, cnt_d;
   logic [IW-1:0] idx, idx_d;
   logic [W-1:0]  sh, sh_d;
   logic          so_d;

   // State, counters, shift register and the registered line output.
   always_ff @(posedge ck) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         so    <= 1'b1;
      end else begin
         state <= nstate;
         cnt   <= cnt_d;
         idx   <= idx_d;
         sh    <= sh_d;
         so    <= so_d;
      end
   end

   // Next-state logic: bit-period down-counter and bit index advance per state.
   always_comb begin
      nstate = state;
      cnt_d  = cnt;
      idx_d  = idx;
      sh_d   = sh;
      case (state)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (xv) begin
               nstate = START;
               cnt_d  = CNT_MAX;
               sh_d   = x;
            end
         end
         START: begin
            if (cnt == '0) begin
               nstate = DATA;
               cnt_d  = CNT_MAX;
               idx_d  = '0;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         DATA: begin
            if (cnt == '0) begin
               cnt_d = CNT_MAX;
               if (idx == IDX_MAX) begin
                  nstate = STOP;
                  idx_d  = '0;
               end else begin
                  idx_d = idx + 1'b1;
                  sh_d  = sh >> 1;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         STOP: begin
            if (cnt == '0) begin
               nstate = IDLE;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         default: begin
            nstate = IDLE;
            cnt_d  = '0;
            idx_d  = '0;
         end
      endcase
   end

   // Outputs: handshake from the current state; line level from the next state
   // so that so is registered yet changes in step with the state.
   always_comb begin
      ready = (state == IDLE);
      busy  = ~ready;
      case (nstate)
         START:   so_d = 1'b0;
         DATA:    so_d = sh_d[0];
         default: so_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a DIV=4 and a DIV=1 instance checked cycle by cycle
// against a frame model computed from the bit-period arithmetic.
module tb_serial_tx;

   logic       ck = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] x0 = '0, x1 = '0;
   logic       xv0 = 1'b0, xv1 = 1'b0;
   logic       ready0, so0, busy0;
   logic       ready1, so1, busy1;

   int checks = 0;
   int errors = 0;

   always #5 ck = ~ck;

   serial_tx #(.W(8), .DIV(4)) dut0 (
      .ck(ck), .reset(reset), .x(x0), .xv(xv0),
      .ready(ready0), .so(so0), .busy(busy0)
   );

   serial_tx #(.W(8), .DIV(1)) dut1 (
      .ck(ck), .reset(reset), .x(x1), .xv(xv1),
      .ready(ready1), .so(so1), .busy(busy1)
   );

   // Expected line level k cycles after the transfer edge (k = 0 is the first
   // start-bit cycle): bit slot k/div is start, data[0..7], stop, then idle.
   function automatic logic exp_so(input logic [7:0] w, input int div, input int k);
      int slot;
      slot = k / div;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return w[slot-1];
      return 1'b1;
   endfunction

   function automatic logic exp_ready(input int div, input int k);
      return (k >= 10 * div);
   endfunction

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      xv0 = 1'b0; xv1 = 1'b0;
      tick(); tick();
      checks++;
      if (so0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut0 so=%b ready=%b busy=%b required 1 1 0", so0, ready0, busy0);
      end
      checks++;
      if (so1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut1 so=%b ready=%b busy=%b required 1 1 0", so1, ready1, busy1);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (so0 !== 1'b1 || ready0 !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_reset so=%b ready=%b required 1 1", so0, ready0);
      end
   endtask

   task automatic test_single();
      x0 = 8'h35; xv0 = 1'b1;
      tick();
      xv0 = 1'b0; x0 = $urandom;
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (so0 !== exp_so(8'h35, 4, k) || ready0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL single k=%0d so=%b ready=%b busy=%b required so=%b ready=0 busy=1",
                     k, so0, ready0, busy0, exp_so(8'h35, 4, k));
         end
         tick();
      end
      checks++;
      if (ready0 !== 1'b1 || busy0 !== 1'b0 || so0 !== 1'b1) begin
         errors++;
         $display("FAIL single_end ready=%b busy=%b so=%b required 1 0 1", ready0, busy0, so0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      x0 = 8'h35; xv0 = 1'b1;
      tick();
      x0 = 8'h51;
      for (int k = 0; k < 40; k++) begin
         checks++;
         if (so0 !== exp_so(8'h35, 4, k) || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first k=%0d so=%b ready=%b required so=%b ready=0",
                     k, so0, ready0, exp_so(8'h35, 4, k));
         end
         tick();
      end
      checks++;
      if (so0 !== 1'b1 || ready0 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap so=%b ready=%b required 1 1", so0, ready0);
      end
      tick();
      xv0 = 1'b0;
      w = 8'h51;
      for (int k = 0; k <= 40; k++) begin
         checks++;
         if (so0 !== exp_so(w, 4, k) || ready0 !== exp_ready(4, k)) begin
            errors++;
            $display("FAIL b2b_second k=%0d so=%b ready=%b required so=%b ready=%b",
                     k, so0, ready0, exp_so(w, 4, k), exp_ready(4, k));
         end
         if (k < 40) tick();
      end
   endtask

   task automatic test_ignore_input();
      x0 = 8'h35; xv0 = 1'b1;
      tick();
      xv0 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k == 10) begin
            x0 = 8'hFF; xv0 = 1'b1;
         end
         checks++;
         if (so0 !== exp_so(8'h35, 4, k)) begin
            errors++;
            $display("FAIL ignore_frame k=%0d so=%b required %b", k, so0, exp_so(8'h35, 4, k));
         end
         tick();
      end
      checks++;
      if (ready0 !== 1'b1 || so0 !== 1'b1) begin
         errors++;
         $display("FAIL ignore_idle ready=%b so=%b required 1 1", ready0, so0);
      end
      tick();
      xv0 = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         checks++;
         if (so0 !== exp_so(8'hFF, 4, k) || ready0 !== exp_ready(4, k)) begin
            errors++;
            $display("FAIL ignore_next k=%0d so=%b ready=%b required so=%b ready=%b",
                     k, so0, ready0, exp_so(8'hFF, 4, k), exp_ready(4, k));
         end
         if (k < 40) tick();
      end
   endtask

   task automatic test_reset_mid_frame();
      x0 = 8'h35; xv0 = 1'b1;
      tick();
      xv0 = 1'b0;
      for (int k = 0; k < 17; k++) begin
         checks++;
         if (so0 !== exp_so(8'h35, 4, k)) begin
            errors++;
            $display("FAIL abort_pre k=%0d so=%b required %b", k, so0, exp_so(8'h35, 4, k));
         end
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (so0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL abort so=%b ready=%b busy=%b required 1 1 0", so0, ready0, busy0);
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (so0 !== 1'b1 || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet k=%0d so=%b ready=%b required 1 1", k, so0, ready0);
         end
      end
      x0 = 8'hA5; xv0 = 1'b1;
      tick();
      xv0 = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         checks++;
         if (so0 !== exp_so(8'hA5, 4, k) || ready0 !== exp_ready(4, k)) begin
            errors++;
            $display("FAIL abort_resend k=%0d so=%b ready=%b required so=%b ready=%b",
                     k, so0, ready0, exp_so(8'hA5, 4, k), exp_ready(4, k));
         end
         if (k < 40) tick();
      end
   endtask

   task automatic test_reset_priority();
      x0 = 8'h35; xv0 = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; xv0 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (so0 !== 1'b1 || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority k=%0d so=%b ready=%b required 1 1", k, so0, ready0);
         end
         tick();
      end
   endtask

   task automatic test_div1();
      x1 = 8'h80; xv1 = 1'b1;
      tick();
      xv1 = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if (so1 !== exp_so(8'h80, 1, k) || ready1 !== exp_ready(1, k) || busy1 !== ~exp_ready(1, k)) begin
            errors++;
            $display("FAIL div1 k=%0d so=%b ready=%b busy=%b required so=%b ready=%b",
                     k, so1, ready1, busy1, exp_so(8'h80, 1, k), exp_ready(1, k));
         end
         if (k < 10) tick();
      end
   endtask

   task automatic test_random();
      logic [7:0] w;
      int         div;
      int         gap;
      logic       s, r;
      for (int n = 0; n < 16; n++) begin
         div = (n % 2 == 0) ? 4 : 1;
         w   = 8'($urandom);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            if (div == 4) x0 = 8'($urandom); else x1 = 8'($urandom);
            tick();
            s = (div == 4) ? so0 : so1;
            r = (div == 4) ? ready0 : ready1;
            checks++;
            if (s !== 1'b1 || r !== 1'b1) begin
               errors++;
               $display("FAIL rand_idle n=%0d so=%b ready=%b required 1 1", n, s, r);
            end
         end
         if (div == 4) begin x0 = w; xv0 = 1'b1; end
         else          begin x1 = w; xv1 = 1'b1; end
         tick();
         xv0 = 1'b0; xv1 = 1'b0;
         x0 = 8'($urandom); x1 = 8'($urandom);
         for (int k = 0; k <= 10 * div; k++) begin
            s = (div == 4) ? so0 : so1;
            r = (div == 4) ? ready0 : ready1;
            checks++;
            if (s !== exp_so(w, div, k) || r !== exp_ready(div, k)) begin
               errors++;
               $display("FAIL rand n=%0d w=%h div=%0d k=%0d so=%b ready=%b required so=%b ready=%b",
                        n, w, div, k, s, r, exp_so(w, div, k), exp_ready(div, k));
            end
            if (k < 10 * div) tick();
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_input();
      test_reset_mid_frame();
      test_reset_priority();
      test_div1();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
- REQ-001 The module SHALL have parameter W, default 8, meaning data word width in bits; legal range W >= 1.
- REQ-002 The module SHALL have parameter DIV, default 4, meaning clock cycles per serial bit period; legal range DIV >= 1.
- REQ-003 The module SHALL have port ck, input, width 1, the single clock; all state changes on its rising edge.
- REQ-004 The module SHALL have port reset, input, width 1, a synchronous active-high reset.
- REQ-005 The module SHALL have port x, input, width W, the parallel word to transmit, typically the q output of the upstream universal register.
- REQ-006 The module SHALL have port xv, input, width 1, asserted while x holds a valid word.
- REQ-007 The module SHALL have port ready, output, width 1, asserted when the module can accept a word.
- REQ-008 The module SHALL have port so, output, width 1, the registered serial line output, idle level 1.
- REQ-009 The module SHALL have port busy, output, width 1, equal to the complement of ready.

Function
- REQ-010 The module SHALL implement states IDLE, START, DATA and STOP.
- REQ-011 The module SHALL assert ready = 1 only in IDLE.
- REQ-012 A transfer SHALL occur on a rising edge with xv = 1 and ready = 1, capturing x into an internal W-bit shift register and moving to START.
- REQ-013 In IDLE with xv = 0, the module SHALL remain in IDLE with so = 1.
- REQ-014 The module SHALL drive so = 0 for exactly DIV cycles in START, beginning the cycle after the transfer edge.
- REQ-015 In DATA, the module SHALL send the captured word LSB first, holding each bit on so for exactly DIV cycles: W*DIV cycles in total.
- REQ-016 The module SHALL drive so = 1 for exactly DIV cycles in STOP, then enter IDLE.
- REQ-017 A frame SHALL occupy (W+2)*DIV cycles from the transfer edge to IDLE entry, and ready SHALL be 1 in the first cycle after the frame.
- REQ-018 Consecutive frames SHALL be separated by at least one IDLE cycle with so = 1, giving a minimum word-to-word spacing of (W+2)*DIV+1 cycles.
- REQ-019 Changes on x and xv outside a transfer edge SHALL NOT affect a frame in progress.
- REQ-020 Bit timing SHALL use a down-counter wide enough for DIV-1.
- REQ-021 The bit index SHALL use a counter wide enough for W-1, and neither counter SHALL wrap outside its state.
- REQ-022 With DIV = 1, each bit SHALL last exactly one cycle, with no skipped or repeated bits.
- REQ-023 The output so SHALL come directly from a flip-flop, with no combinational path from x or xv.

Reset
- REQ-024 While reset = 1 at a rising edge, the next state SHALL be IDLE, with so = 1, ready = 1, busy = 0, and both counters cleared.
- REQ-025 Reset SHALL take priority over any transfer at the same edge; a word presented with xv = 1 at that edge is not accepted.
- REQ-026 Reset asserted mid-frame SHALL abort the frame, with so = 1 from the following cycle, and no remaining bits sent.

Verification (W=8, DIV=4)
- REQ-027 Single word: x=8'h35, xv pulsed 1 cycle in IDLE -> so holds 0,1,0,1,0,1,1,0,0,1 for 4 cycles each; ready returns 1 exactly 40 cycles after the transfer edge.
- REQ-028 Back-to-back: xv held 1 with x=8'h35 then 8'h51 -> second start bit begins 41 cycles after the first; second frame reads 0,1,0,0,0,1,0,1,0,1.
- REQ-029 Ignored input: x changed to 8'hFF mid-frame with xv=1 -> frame still carries 8'h35; 8'hFF accepted only at the next ready=1 edge.
- REQ-030 Reset mid-frame: reset for 1 cycle during data bit 3 -> so=1, ready=1 next cycle; a new word 8'hA5 then transmits a complete correct frame.
- REQ-031 Reset priority: reset=1 and xv=1 at the same edge -> no frame starts, so stays 1.
- REQ-032 DIV=1 instance, x=8'h80 -> so reads 0,0,0,0,0,0,0,0,1,1 on consecutive cycles; ready returns 1 after 10 cycles.
